// File: rtl/algo_mrpnwp_sched_pkg.sv
// Shared types and helpers for the multiport write-port scheduler.
//   sched_state_e : scheduler FSM state (INIT waits for memory ready, RUN grants)
//   mod_add       : (a + b) mod m with an explicit single wrap, for a, b < m
package algo_mrpnwp_sched_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    // Single conditional subtract; valid because both operands are already < m.
    function automatic int unsigned mod_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned m);
        int unsigned s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

endpackage

// File: rtl/algo_mrpnwp_rr_pick.sv
// Fixed-priority picker over a request vector already rotated so that bit 0
// is the highest priority. Grants up to NUMWRPT requests and packs them onto
// ports 0.. in priority order.
// Optional feature macro: ALGO_WRSCHED_ADRCONF_EN (defer a request whose
// address matches a higher-priority request granted in the same cycle).
//   rreq_i  : rotated request valids
//   radr_i  : rotated request addresses
//   rgnt_o  : rotated grant mask
//   pvld_o  : per-port valid
//   pidx_o  : per-port rotated requester index
module algo_mrpnwp_rr_pick #(
    parameter int unsigned NUMREQ  = 12,
    parameter int unsigned BITREQ  = 4,
    parameter int unsigned NUMWRPT = 9,
    parameter int unsigned BITADDR = 13
) (
    input  logic [NUMREQ-1:0]         rreq_i,
    input  logic [NUMREQ*BITADDR-1:0] rreq_adr_i,
    output logic [NUMREQ-1:0]         rgnt_o,
    output logic [NUMWRPT-1:0]        pvld_o,
    output logic [NUMWRPT*BITREQ-1:0] pidx_o
);

    localparam int unsigned BITPORT = $clog2(NUMWRPT + 1);

`ifndef ALGO_WRSCHED_ADRCONF_EN
    logic unused_adr;
    assign unused_adr = ^rreq_adr_i;
`endif

    // Walk candidates in priority order, filling ports as grants are made.
    always_comb begin
        logic [BITPORT-1:0] cnt;
        logic [NUMREQ-1:0]  g;
        logic               elig;
        g      = '0;
        pvld_o = '0;
        pidx_o = '0;
        cnt    = '0;
        elig   = 1'b0;
        for (int j = 0; j < NUMREQ; j++) begin
            elig = rreq_i[j] && (32'(cnt) < NUMWRPT);
`ifdef ALGO_WRSCHED_ADRCONF_EN
            // Only earlier (higher-priority) candidates that actually won are compared.
            for (int h = 0; h < j; h++) begin
                if (g[h] && (rreq_adr_i[h*BITADDR +: BITADDR] == rreq_adr_i[j*BITADDR +: BITADDR])) begin
                    elig = 1'b0;
                end
            end
`endif
            if (elig) begin
                g[j]                          = 1'b1;
                pvld_o[cnt]                   = 1'b1;
                pidx_o[cnt*BITREQ +: BITREQ]  = BITREQ'(j);
                cnt                           = cnt + 1'b1;
            end
        end
        rgnt_o = g;
    end

endmodule

// File: rtl/algo_mrpnwp_wr_sched.sv
// Round-robin write-port scheduler in front of the multiport memory. Grants up
// to NUMWRPT of NUMREQ requesters per cycle (gnt is combinational) and drives
// the granted writes onto the memory port vector one cycle later.
// Optional feature macro: ALGO_WRSCHED_ADRCONF_EN (same-cycle address-conflict
// deferral, implemented in algo_mrpnwp_rr_pick).
//   clk, rst   : clock, asynchronous active-high reset
//   mem_ready  : memory ready; low stops granting in the same cycle
//   req/req_adr/req_din : per-requester request, address, data
//   gnt        : per-requester grant (combinational)
//   write/wr_adr/din    : registered memory write port vector
//   sched_busy : registered, requests left ungranted in RUN
module algo_mrpnwp_wr_sched
    import algo_mrpnwp_sched_pkg::*;
#(
    parameter int unsigned NUMREQ  = 12,
    parameter int unsigned BITREQ  = 4,
    parameter int unsigned NUMWRPT = 9,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned BITADDR = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_ready,
    input  logic [NUMREQ-1:0]          req,
    input  logic [NUMREQ*BITADDR-1:0]  req_adr,
    input  logic [NUMREQ*WIDTH-1:0]    req_din,
    output logic [NUMREQ-1:0]          gnt,
    output logic [NUMWRPT-1:0]         write,
    output logic [NUMWRPT*BITADDR-1:0] wr_adr,
    output logic [NUMWRPT*WIDTH-1:0]   din,
    output logic                       sched_busy
);

    sched_state_e               state_q;
    logic [BITREQ-1:0]          ptr_q;
    logic [BITREQ-1:0]          ptr_d;
    logic [NUMWRPT-1:0]         write_q;
    logic [NUMWRPT*BITADDR-1:0] wr_adr_q;
    logic [NUMWRPT*WIDTH-1:0]   din_q;
    logic                       busy_q;

    logic                       grant_en;
    logic [NUMREQ-1:0]          rreq;
    logic [NUMREQ*BITADDR-1:0]  radr;
    logic [NUMREQ-1:0]          rgnt;
    logic [NUMWRPT-1:0]         pvld;
    logic [NUMWRPT*BITREQ-1:0]  pidx;
    logic [NUMWRPT*BITADDR-1:0] port_adr;
    logic [NUMWRPT*WIDTH-1:0]   port_din;

    // mem_ready is used directly so a deassert blocks grants in the same cycle.
    assign grant_en = (state_q == RUN) && mem_ready;

    // Rotate requests so requester ptr sits at position 0; un-rotate grants.
    always_comb begin
        logic [BITREQ-1:0] ridx;
        rreq = '0;
        radr = '0;
        gnt  = '0;
        ridx = '0;
        for (int j = 0; j < NUMREQ; j++) begin
            ridx = BITREQ'(mod_add(32'(ptr_q), j, NUMREQ));
            rreq[j]                      = req[ridx];
            radr[j*BITADDR +: BITADDR]   = req_adr[ridx*BITADDR +: BITADDR];
            gnt[ridx]                    = rgnt[j] & grant_en;
        end
    end

    algo_mrpnwp_rr_pick #(
        .NUMREQ  (NUMREQ),
        .BITREQ  (BITREQ),
        .NUMWRPT (NUMWRPT),
        .BITADDR (BITADDR)
    ) u_pick (
        .rreq_i     (rreq),
        .rreq_adr_i (radr),
        .rgnt_o     (rgnt),
        .pvld_o     (pvld),
        .pidx_o     (pidx)
    );

    // Map each port back to its real requester; the last valid port sets the next ptr.
    always_comb begin
        logic [BITREQ-1:0] psrc;
        logic [BITREQ-1:0] last;
        port_adr = '0;
        port_din = '0;
        psrc     = '0;
        last     = ptr_q;
        for (int k = 0; k < NUMWRPT; k++) begin
            psrc = BITREQ'(mod_add(32'(ptr_q), 32'(pidx[k*BITREQ +: BITREQ]), NUMREQ));
            port_adr[k*BITADDR +: BITADDR] = req_adr[psrc*BITADDR +: BITADDR];
            port_din[k*WIDTH +: WIDTH]     = req_din[psrc*WIDTH +: WIDTH];
            if (pvld[k]) begin
                last = psrc;
            end
        end
        ptr_d = BITREQ'(mod_add(32'(last), 1, NUMREQ));
    end

    // FSM, round-robin pointer and registered memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            write_q  <= '0;
            wr_adr_q <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT:    if (mem_ready)  state_q <= RUN;
                RUN:     if (!mem_ready) state_q <= INIT;
                default: state_q <= INIT;
            endcase
            busy_q <= (state_q == RUN) && (|(req & ~gnt));
            for (int k = 0; k < NUMWRPT; k++) begin
                write_q[k] <= grant_en & pvld[k];
                // Unused ports keep their previous address and data.
                if (grant_en && pvld[k]) begin
                    wr_adr_q[k*BITADDR +: BITADDR] <= port_adr[k*BITADDR +: BITADDR];
                    din_q[k*WIDTH +: WIDTH]        <= port_din[k*WIDTH +: WIDTH];
                end
            end
            if (grant_en && (|pvld)) begin
                ptr_q <= ptr_d;
            end
        end
    end

    assign write      = write_q;
    assign wr_adr     = wr_adr_q;
    assign din        = din_q;
    assign sched_busy = busy_q;

endmodule

// File: tb/tb_algo_mrpnwp_wr_sched.sv
// Self-checking bench for algo_mrpnwp_wr_sched: a behavioural model predicts
// gnt each cycle and queues the expected write-port contents, which are
// compared one cycle later; directed checks cover the named scenarios.
module tb_algo_mrpnwp_wr_sched;
    import algo_mrpnwp_sched_pkg::*;

    localparam int unsigned NUMREQ  = 12;
    localparam int unsigned BITREQ  = 4;
    localparam int unsigned NUMWRPT = 9;
    localparam int unsigned WIDTH   = 64;
    localparam int unsigned BITADDR = 13;
    localparam int unsigned VW      = NUMWRPT * WIDTH;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       mem_ready;
    logic [NUMREQ-1:0]          req;
    logic [NUMREQ*BITADDR-1:0]  req_adr;
    logic [NUMREQ*WIDTH-1:0]    req_din;
    logic [NUMREQ-1:0]          gnt;
    logic [NUMWRPT-1:0]         write;
    logic [NUMWRPT*BITADDR-1:0] wr_adr;
    logic [NUMWRPT*WIDTH-1:0]   din;
    logic                       sched_busy;

    algo_mrpnwp_wr_sched #(
        .NUMREQ (NUMREQ), .BITREQ (BITREQ), .NUMWRPT (NUMWRPT),
        .WIDTH  (WIDTH),  .BITADDR (BITADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .req        (req),
        .req_adr    (req_adr),
        .req_din    (req_din),
        .gnt        (gnt),
        .write      (write),
        .wr_adr     (wr_adr),
        .din        (din),
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUMWRPT-1:0]         wr;
        logic [NUMWRPT*BITADDR-1:0] adr;
        logic [VW-1:0]              dat;
        logic                       busy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state
    int                         m_state;
    int                         m_ptr;
    logic [NUMWRPT*BITADDR-1:0] m_adr;
    logic [VW-1:0]              m_din;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_adr   = '0;
        m_din   = '0;
        sb_q.delete();
    endtask

    task automatic set_req(input int i, input logic [BITADDR-1:0] a, input logic [WIDTH-1:0] d);
        req[i]                        = 1'b1;
        req_adr[i*BITADDR +: BITADDR] = a;
        req_din[i*WIDTH +: WIDTH]     = d;
    endtask

    // One clock: predict and check gnt mid-cycle, then check the registered port after the edge.
    task automatic run_cycle();
        logic [NUMREQ-1:0] eg;
        exp_t              e;
        exp_t              o;
        int                k;
        int                last;
        bit                en;
`ifdef ALGO_WRSCHED_ADRCONF_EN
        logic [BITADDR-1:0] used[$];
`endif
        @(negedge clk);
        eg   = '0;
        k    = 0;
        last = -1;
        en   = (m_state == 1) && (mem_ready == 1'b1);
        e.wr  = '0;
        e.adr = m_adr;
        e.dat = m_din;
        if (en) begin
            for (int p = 0; p < NUMREQ; p++) begin
                int               i;
                logic [BITADDR-1:0] a;
                bit               ok;
                i  = (m_ptr + p) % NUMREQ;
                a  = req_adr[i*BITADDR +: BITADDR];
                ok = (req[i] == 1'b1) && (k < NUMWRPT);
`ifdef ALGO_WRSCHED_ADRCONF_EN
                foreach (used[u]) if (used[u] == a) ok = 0;
`endif
                if (ok) begin
                    eg[i] = 1'b1;
                    e.wr[k] = 1'b1;
                    e.adr[k*BITADDR +: BITADDR] = a;
                    e.dat[k*WIDTH +: WIDTH]     = req_din[i*WIDTH +: WIDTH];
`ifdef ALGO_WRSCHED_ADRCONF_EN
                    used.push_back(a);
`endif
                    last = i;
                    k++;
                end
            end
        end
        e.busy = (m_state == 1) && (|(req & ~eg));
        check("gnt", VW'(gnt), VW'(eg));
        sb_q.push_back(e);
        @(posedge clk);
        m_state = mem_ready ? 1 : 0;
        if (last >= 0) m_ptr = (last + 1) % NUMREQ;
        m_adr = e.adr;
        m_din = e.dat;
        #1;
        o = sb_q.pop_front();
        check("write", VW'(write), VW'(o.wr));
        check("wr_adr", VW'(wr_adr), VW'(o.adr));
        check("din", din, o.dat);
        check("sched_busy", VW'(sched_busy), VW'(o.busy));
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; req = '0; req_adr = '0; req_din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", VW'(write), '0);
        check("rst_wr_adr", VW'(wr_adr), '0);
        check("rst_din", din, '0);
        check("rst_busy", VW'(sched_busy), '0);
        check("rst_gnt", VW'(gnt), '0);
        check("rst_ptr", VW'(dut.ptr_q), '0);
        rst = 1'b0;

        // Single requester held from cycle 0, memory ready during cycle 2 -> RUN at cycle 3.
        set_req(0, 13'h0010, 64'hDEAD_BEEF_0000_0001);
        run_cycle(); run_cycle();
        mem_ready = 1'b1;
        run_cycle();
        check("t1_gnt_c3", VW'(gnt), VW'(12'h001));
        run_cycle();
        check("t1_write_c4", VW'(write), VW'(9'h001));
        check("t1_adr_c4", VW'(wr_adr[BITADDR-1:0]), VW'(13'h0010));
        check("t1_ptr", VW'(dut.ptr_q), VW'(4'd1));
        req = '0;
        run_cycle();
        check("t1_one_shot", VW'(write), '0);

        // Get ptr back to 0 via requester 11.
        set_req(11, 13'h0011, 64'h11);
        run_cycle(); req = '0;
        check("t2_ptr0", VW'(dut.ptr_q), '0);

        // All twelve requesters, distinct addresses.
        for (int i = 0; i < NUMREQ; i++) set_req(i, BITADDR'(13'h100 + i * 17), {$urandom, $urandom});
        run_cycle();
        check("t2_write_all", VW'(write), VW'(9'h1FF));
        check("t2_busy", VW'(sched_busy), VW'(1'b1));
        check("t2_ptr9", VW'(dut.ptr_q), VW'(4'd9));
        req = 12'hE00;
        run_cycle();
        check("t2_write_wrap", VW'(write), VW'(9'h007));
        check("t2_ptr_wrap", VW'(dut.ptr_q), '0);
        req = '0;

        // ptr=10, requesters 2 and 11.
        set_req(9, 13'h0042, 64'h9);
        run_cycle(); req = '0;
        check("t3_ptr10", VW'(dut.ptr_q), VW'(4'd10));
        set_req(2, 13'h0202, 64'h2222);
        set_req(11, 13'h0B0B, 64'hBBBB);
        run_cycle(); req = '0;
        check("t3_port0", VW'(wr_adr[0 +: BITADDR]), VW'(13'h0B0B));
        check("t3_port1", VW'(wr_adr[BITADDR +: BITADDR]), VW'(13'h0202));
        check("t3_ptr3", VW'(dut.ptr_q), VW'(4'd3));

        // Same-address pair at ptr=0.
        set_req(11, 13'h0001, 64'h1);
        run_cycle(); req = '0;
        set_req(0, 13'h1ABC, 64'hA0);
        set_req(1, 13'h1ABC, 64'hA1);
        run_cycle();
`ifdef ALGO_WRSCHED_ADRCONF_EN
        check("t4_conf_write", VW'(write), VW'(9'h001));
`else
        check("t4_dup_write", VW'(write), VW'(9'h003));
`endif
        req = 12'h002;
        run_cycle();
        check("t4_second", VW'(write), VW'(9'h001));
        check("t4_second_din", VW'(din[WIDTH-1:0]), VW'(64'hA1));
        req = '0;

        // mem_ready drops with five requests pending.
        for (int i = 0; i < 5; i++) set_req(i, BITADDR'(13'h300 + i), 64'(i + 32'h50));
        mem_ready = 1'b0;
        run_cycle();
        check("t5_state_init", VW'(dut.state_q), VW'(INIT));
        check("t5_ptr_hold", VW'(dut.ptr_q), VW'(4'd2));
        mem_ready = 1'b1;
        run_cycle();
        run_cycle();
        check("t5_resume_port0", VW'(wr_adr[0 +: BITADDR]), VW'(13'h302));
        req = '0;

        // Randomised traffic with a small address pool to exercise duplicates.
        for (int c = 0; c < 60; c++) begin
            req = NUMREQ'($urandom);
            for (int i = 0; i < NUMREQ; i++) begin
                req_adr[i*BITADDR +: BITADDR] = BITADDR'($urandom_range(0, 5));
                req_din[i*WIDTH +: WIDTH]     = {$urandom, $urandom};
            end
            mem_ready = ($urandom_range(0, 7) != 0);
            run_cycle();
        end

        // Asynchronous reset while all nine ports are writing.
        req = '0; mem_ready = 1'b1;
        run_cycle(); run_cycle();
        for (int i = 0; i < NUMREQ; i++) set_req(i, BITADDR'(13'h500 + i), {$urandom, $urandom});
        run_cycle();
        check("t6_write_full", VW'(write), VW'(9'h1FF));
        #2 rst = 1'b1;
        #1;
        check("t6_write_clr", VW'(write), '0);
        check("t6_adr_clr", VW'(wr_adr), '0);
        check("t6_din_clr", din, '0);
        check("t6_busy_clr", VW'(sched_busy), '0);
        check("t6_state", VW'(dut.state_q), VW'(INIT));
        check("t6_gnt", VW'(gnt), '0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
        run_cycle(); run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/algo_mrpnwp_wr_sched.md
# algo_mrpnwp_wr_sched

Write-port scheduler in front of the 9R9W multiport memory top. It accepts write requests from NUMREQ independent requesters over a req/gnt handshake. Each cycle it grants up to NUMWRPT of them in round-robin order and packs them onto the memory's write/wr_adr/din port vector one cycle later. It holds all grants while the memory is not `ready`, and it defers same-cycle requests to an already-granted address.

## Interface
- NUMREQ, 12, number of requesters (must be ≥ NUMWRPT)
- BITREQ, 4, clog2(NUMREQ)
- NUMWRPT, 9, memory write ports
- WIDTH, 64, data width
- BITADDR, 13, address width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_ready  in  1  memory `ready` output
- req  in  NUMREQ  request valid, one bit per requester; held with adr/din until granted
- req_adr  in  NUMREQ*BITADDR  request addresses, requester i at [i*BITADDR +: BITADDR]
- req_din  in  NUMREQ*WIDTH  request data
- gnt  out  NUMREQ  grant; combinational, same cycle as accepted req
- write  out  NUMWRPT  memory write enables (registered)
- wr_adr  out  NUMWRPT*BITADDR  memory write addresses (registered)
- din  out  NUMWRPT*WIDTH  memory write data (registered)
- sched_busy  out  1  high in RUN while at least one req is left ungranted this cycle (registered)

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT.
  - INIT→RUN when mem_ready=1.
  - RUN→INIT when mem_ready=0.
- In INIT, gnt=0 and no writes issue.
- Priority order: rotate req by ptr (BITREQ bits, reset 0), so requester ptr has the highest priority, then ptr+1, and so on, mod NUMREQ.
- The first NUMWRPT eligible requests in priority order are granted. The k-th granted request occupies port k (0-based). Ports k..NUMWRPT-1 get write=0, and their adr/din hold previous values.
- Eligibility requires req[i]=1, plus the address-conflict rule (see Configuration).
- ptr update:
  - In a cycle with ≥1 grant, ptr ← (last granted index + 1) mod NUMREQ, with explicit wrap (no power-of-two assumption).
  - In a cycle with no grant, ptr holds.
- A requester whose gnt=1 must drop req or present a new request on the next cycle. The scheduler does not track a pending request across cycles beyond ptr.
- sched_busy ← (state==RUN) && (|(req & ~gnt)).
- A mem_ready deassert is seen combinationally: no grant issues in that cycle. Writes already registered in the previous cycle still drive for one cycle.

## Timing
- Reset values: write=0, wr_adr=0, din=0, sched_busy=0, ptr=0, state=INIT. gnt=0 while in INIT.
- gnt is combinational from req, req_adr, ptr and state. There is no combinational path from req to write/wr_adr/din.
- Latency: a request granted in cycle N appears on write/wr_adr/din in cycle N+1, for exactly one cycle.
- Worst-case wait for requester i with req held continuously in RUN is ceil(NUMREQ/NUMWRPT) cycles, which is 2 with the defaults.
- If rst asserts mid-operation, all outputs clear immediately. Writes registered but not yet consumed are dropped.

## Configuration
- ALGO_WRSCHED_ADRCONF_EN defined:
  - A request is ineligible if its address equals the address of a higher-priority request already granted in the same cycle.
  - The deferred request retries next cycle and does not consume a port.
  - The pairwise compare is restricted to candidates in priority order.
- Not defined:
  - No address compare.
  - Duplicate addresses may be granted on different ports in one cycle, with memory resolution undefined.
  - The compare logic is absent.

## Structure
- Package algo_mrpnwp_sched_pkg holds:
  - the state typedef (INIT, RUN)
  - a localparam function for mod-NUMREQ increment
- Sub-module algo_mrpnwp_rr_pick:
  - inputs: rotated request vector, rotated address vector
  - outputs: grant mask and per-port requester index
  - instantiated once
- The top does rotation, output registers, ptr and the FSM.

## Test plan
- Reset then mem_ready=1 at cycle 3, with req=12'h001 and adr 0x0010 held from cycle 0:
  - gnt[0]=1 first at cycle 3.
  - write=9'h001 with wr_adr[0]=0x0010 at cycle 4.
  - ptr=1.
- All 12 requesters, ptr=0, distinct addresses:
  - Cycle N grants 0–8 on ports 0–8; ptr=9; sched_busy=1.
  - Cycle N+1 grants 9,10,11 on ports 0–2; ptr=0 (wrap).
- ptr=10, req from requesters 2 and 11 only:
  - Requester 11 lands on port 0 and requester 2 on port 1.
  - ptr becomes 3.
- Macro on, requesters 0 and 1 both adr 0x1ABC, ptr=0:
  - Cycle N grants only 0.
  - Cycle N+1 grants 1.
  - Macro off: both are granted in cycle N on ports 0 and 1.
- mem_ready drops in RUN with 5 reqs pending:
  - gnt=0 the same cycle; state=INIT; write=0 from the next cycle; ptr holds.
  - On mem_ready return, granting resumes from the held ptr.
- rst asserted asynchronously mid-cycle while write=9'h1FF:
  - write, wr_adr, din and sched_busy clear to 0 before the next edge.
  - state=INIT.
